// File: rtl/run_ctrl.sv
// Run controller for the barrel core: sequences the core's reset, waits for halt,
// and enforces a RUN-cycle watchdog. Every output comes straight from a flop.
module run_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT      = 1000,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             halt,
  output logic             core_resetn,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic [1:0]       state_dbg
);

  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    TMO    = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [HW-1:0]    hold_cnt, hold_cnt_n;
  logic             core_resetn_n, running_n, done_n, timeout_n;
  logic [CNT_W-1:0] cycles_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      core_resetn <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycles      <= '0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_cnt_n;
      core_resetn <= core_resetn_n;
      running     <= running_n;
      done        <= done_n;
      timeout     <= timeout_n;
      cycles      <= cycles_n;
    end
  end

  always_comb begin
    state_n       = state;
    hold_cnt_n    = hold_cnt;
    core_resetn_n = core_resetn;
    running_n     = running;
    done_n        = done;
    timeout_n     = timeout;
    cycles_n      = cycles;
    unique case (state)
      HOLD: begin
        core_resetn_n = 1'b0;
        if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
          state_n       = RUN;
          hold_cnt_n    = '0;
          core_resetn_n = 1'b1;
          running_n     = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      RUN: begin
        // Halt is checked first so a halt on the expiry edge reports done, not timeout.
        if (halt) begin
          state_n   = HALTED;
          done_n    = 1'b1;
          running_n = 1'b0;
        end else if (cycles == CNT_W'(TIMEOUT - 1)) begin
          state_n       = TMO;
          timeout_n     = 1'b1;
          running_n     = 1'b0;
          core_resetn_n = 1'b0;
          cycles_n      = CNT_W'(TIMEOUT);
        end else begin
          cycles_n = cycles + CNT_W'(1);
        end
      end
      HALTED, TMO: begin
        if (start) begin
          state_n       = HOLD;
          hold_cnt_n    = '0;
          core_resetn_n = 1'b0;
          running_n     = 1'b0;
          done_n        = 1'b0;
          timeout_n     = 1'b0;
          cycles_n      = '0;
        end
      end
      default: state_n = HOLD;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: drivers push expected snapshots into a queue and a
// negedge monitor pops and compares them against the selected instance.
module tb_run_ctrl;

  localparam int W = 39;

  logic        clk;
  logic        resetn, start, halt;
  logic        resetn8, start8, halt8;
  logic        core_resetn, running, done, timeout;
  logic        core_resetn8, running8, done8, timeout8;
  logic [31:0] cycles, cycles8;
  logic [1:0]  state_dbg, state_dbg8;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  localparam logic [1:0] S_HOLD = 2'd0, S_RUN = 2'd1, S_HALTED = 2'd2, S_TMO = 2'd3;

  run_ctrl #(.RESET_CYCLES(2), .TIMEOUT(1000), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .halt(halt),
    .core_resetn(core_resetn), .running(running), .done(done), .timeout(timeout),
    .cycles(cycles), .state_dbg(state_dbg)
  );

  run_ctrl #(.RESET_CYCLES(2), .TIMEOUT(8), .CNT_W(32)) dut8 (
    .clk(clk), .resetn(resetn8), .start(start8), .halt(halt8),
    .core_resetn(core_resetn8), .running(running8), .done(done8), .timeout(timeout8),
    .cycles(cycles8), .state_dbg(state_dbg8)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: bench did not finish within the time budget");
    $fatal(1);
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string nm, input logic sel, input logic [1:0] st,
                           input logic cr, input logic rn, input logic dn,
                           input logic tm, input logic [31:0] cyc);
    exp_q.push_back({sel, st, cr, rn, dn, tm, cyc});
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  logic [W-1:0] act0, act8;
  assign act0 = {1'b0, state_dbg, core_resetn, running, done, timeout, cycles};
  assign act8 = {1'b1, state_dbg8, core_resetn8, running8, done8, timeout8, cycles8};

  always @(negedge clk) begin
    logic [W-1:0] e, a;
    string        nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = e[W-1] ? act8 : act0;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got st=%0d cr=%b run=%b done=%b tmo=%b cyc=%0d, expected st=%0d cr=%b run=%b done=%b tmo=%b cyc=%0d",
                 nm, a[37:36], a[35], a[34], a[33], a[32], a[31:0],
                 e[37:36], e[35], e[34], e[33], e[32], e[31:0]);
      end
    end
  end

  // stimulus
  initial begin
    resetn = 1'b0; start = 1'b0; halt = 1'b0;
    resetn8 = 1'b0; start8 = 1'b0; halt8 = 1'b0;
    step(3);
    expect_st("reset_state", 0, S_HOLD, 0, 0, 0, 0, 0);
    step(1);

    // Undisturbed run into the watchdog
    resetn = 1'b1;
    step(1);
    expect_st("hold_edge1", 0, S_HOLD, 0, 0, 0, 0, 0);
    step(1);
    expect_st("run_entry", 0, S_RUN, 1, 1, 0, 0, 0);
    step(999);
    expect_st("run_999", 0, S_RUN, 1, 1, 0, 0, 999);
    step(1);
    expect_st("watchdog_fire", 0, S_TMO, 0, 0, 0, 1, 1000);
    step(3);
    expect_st("tmo_holds", 0, S_TMO, 0, 0, 0, 1, 1000);

    // Restart from TMO, halt after 37 cycles
    start = 1'b1;
    step(1);
    start = 1'b0;
    expect_st("restart_from_tmo", 0, S_HOLD, 0, 0, 0, 0, 0);
    step(1);
    expect_st("restart_hold1", 0, S_HOLD, 0, 0, 0, 0, 0);
    step(1);
    expect_st("restart_run", 0, S_RUN, 1, 1, 0, 0, 0);
    step(37);
    halt = 1'b1;
    step(1);
    expect_st("halt_37", 0, S_HALTED, 1, 0, 1, 0, 37);
    for (int i = 0; i < 20; i++) begin
      halt = ~halt;
      step(1);
    end
    expect_st("halted_holds", 0, S_HALTED, 1, 0, 1, 0, 37);
    halt = 1'b0;
    step(1);

    // Restart from HALTED, second halt after 5 cycles
    start = 1'b1;
    step(1);
    start = 1'b0;
    expect_st("restart_from_halted", 0, S_HOLD, 0, 0, 0, 0, 0);
    step(2);
    expect_st("restart2_run", 0, S_RUN, 1, 1, 0, 0, 0);
    step(5);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    expect_st("halt_5", 0, S_HALTED, 1, 0, 1, 0, 5);
    step(1);

    // start pulses in HOLD and RUN are ignored
    start = 1'b1;
    step(1);
    expect_st("restart3", 0, S_HOLD, 0, 0, 0, 0, 0);
    step(1);
    start = 1'b0;
    expect_st("start_in_hold", 0, S_HOLD, 0, 0, 0, 0, 0);
    step(1);
    expect_st("hold_timing_kept", 0, S_RUN, 1, 1, 0, 0, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    expect_st("start_in_run", 0, S_RUN, 1, 1, 0, 0, 1);
    step(2);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    expect_st("halt_3", 0, S_HALTED, 1, 0, 1, 0, 3);
    step(1);

    // start held high re-triggers on reaching HALTED
    start = 1'b1;
    step(1);
    expect_st("held_start_restart", 0, S_HOLD, 0, 0, 0, 0, 0);
    step(2);
    expect_st("held_start_run", 0, S_RUN, 1, 1, 0, 0, 0);
    step(2);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    expect_st("held_start_halt", 0, S_HALTED, 1, 0, 1, 0, 2);
    step(1);
    expect_st("held_start_retrigger", 0, S_HOLD, 0, 0, 0, 0, 0);
    start = 1'b0;
    step(2);
    step(5);
    expect_st("pre_async_run", 0, S_RUN, 1, 1, 0, 0, 5);
    step(1);

    // Asynchronous reset mid-RUN, checked before any further edge
    resetn = 1'b0;
    expect_st("async_reset", 0, S_HOLD, 0, 0, 0, 0, 0);
    step(2);
    resetn = 1'b1;
    step(1);
    expect_st("post_reset_hold", 0, S_HOLD, 0, 0, 0, 0, 0);
    step(1);
    expect_st("post_reset_run", 0, S_RUN, 1, 1, 0, 0, 0);
    step(3);
    expect_st("post_reset_count", 0, S_RUN, 1, 1, 0, 0, 3);
    step(1);

    // TIMEOUT=8 instance: halt on the expiry edge wins
    resetn8 = 1'b1;
    step(2);
    expect_st("t8_run_entry", 1, S_RUN, 1, 1, 0, 0, 0);
    step(7);
    halt8 = 1'b1;
    step(1);
    halt8 = 1'b0;
    expect_st("t8_halt_vs_expiry", 1, S_HALTED, 1, 0, 1, 0, 7);
    step(1);
    start8 = 1'b1;
    step(1);
    start8 = 1'b0;
    step(2);
    step(7);
    expect_st("t8_run_7", 1, S_RUN, 1, 1, 0, 0, 7);
    step(1);
    expect_st("t8_timeout", 1, S_TMO, 0, 0, 0, 1, 8);

    step(3);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
